seqdet_gen: RTL and testbench

Parametrised serial sequence detector for the lab board, the next generation of the fixed 2-bit-state detector top. The pattern length and pattern value are programmable, overlapping and non-overlapping detection are run-time selectable, and detections are counted. A raw push-button steps the detector one bit at a time, and the state, output, and count are driven onto the 4-digit seven-segment display. Everything runs on the single board clock, using tick enables rather than derived clocks.

---
 rtl/seqdet_pkg.sv | 56 +++++
 rtl/seqdet_gen_btn_edge.sv | 29 ++
 rtl/seqdet_gen.sv | 122 ++++++++++++
 tb/tb_seqdet_gen.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seqdet_pkg.sv
// rtl/seqdet_pkg.sv - shared constants and helpers for the seqdet_gen detector
package seqdet_pkg;

  // Active-low segment codes, bit order {CG,CF,CE,CD,CC,CB,CA}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // Which scan slot shows which value
  localparam logic [1:0] DIG_STATE  = 2'd0;
  localparam logic [1:0] DIG_Z      = 2'd1;
  localparam logic [1:0] DIG_CNT_LO = 2'd2;
  localparam logic [1:0] DIG_CNT_HI = 2'd3;

  // Bits needed to hold a matched-prefix length of 0..pat_len
  function automatic int state_w(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seqdet_gen_btn_edge.sv
// rtl/seqdet_gen_btn_edge.sv - tick-sampled button synchroniser and rising-edge pulse
module btn_edge (
  input  logic CLKPORT,
  input  logic reset_n,
  input  logic tick,
  input  logic raw,
  output logic pulse
);

  logic q1;
  logic q2;

  // Sample the button only on ticks (filters bounce) and emit a one-cycle pulse on a rising level
  always_ff @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) begin
      q1    <= 1'b0;
      q2    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (tick) begin
        q1    <= raw;
        q2    <= q1;
        pulse <= q1 & ~q2;
      end
    end
  end

endmodule

// File: rtl/seqdet_gen.sv
// rtl/seqdet_gen.sv - programmable serial sequence detector with match counter and 7-seg scan
module seqdet_gen
  import seqdet_pkg::*;
#(
  parameter  int PAT_LEN  = 4,
  parameter  int CNT_W    = 8,
  parameter  int SCAN_BIT = 16,
  localparam int STATE_W  = state_w(PAT_LEN)
) (
  input  logic               CLKPORT,
  input  logic               reset_n,
  input  logic               step_btn,
  input  logic               x,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic               clr_cnt,
  output logic               z,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   match_cnt,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam logic [STATE_W-1:0] FULL = STATE_W'(PAT_LEN);

  logic [SCAN_BIT+1:0] clk_div;
  logic                tick;
  logic                step;
  logic [PAT_LEN-1:0]  hist;
  logic [PAT_LEN-1:0]  hist_nx;
  logic [STATE_W-1:0]  valid;
  logic [STATE_W-1:0]  valid_nx;
  logic [STATE_W-1:0]  state_nx;
  logic                k_ok;
  logic [1:0]          dig;
  logic [3:0]          dig_val;
  logic [3:0]          state4;
  logic [7:0]          cnt8;

  // Free-running divider: low bits make the tick, top two bits pick the digit
  always_ff @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) clk_div <= '0;
    else          clk_div <= clk_div + 1'b1;
  end

  assign tick = &clk_div[SCAN_BIT-1:0];

  btn_edge u_btn (
    .CLKPORT (CLKPORT),
    .reset_n (reset_n),
    .tick    (tick),
    .raw     (step_btn),
    .pulse   (step)
  );

  // Next history and fill level, then the longest pattern prefix ending at the newest bit
  always_comb begin
    hist_nx  = {hist[PAT_LEN-2:0], x};
    valid_nx = (valid == FULL) ? valid : valid + 1'b1;
    if (!overlap && state == FULL) begin
      hist_nx    = '0;
      hist_nx[0] = x;
      valid_nx   = STATE_W'(1);
    end
    state_nx = '0;
    k_ok     = 1'b0;
    for (int k = 1; k <= PAT_LEN; k++) begin
      k_ok = (k <= int'(valid_nx));
      for (int i = 0; i < k; i++) begin
        if (hist_nx[i] != pattern[PAT_LEN-k+i]) k_ok = 1'b0;
      end
      if (k_ok) state_nx = STATE_W'(k);
    end
  end

  // Detector registers advance only on a button step
  always_ff @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) begin
      hist  <= '0;
      valid <= '0;
      state <= '0;
    end else if (step) begin
      hist  <= hist_nx;
      valid <= valid_nx;
      state <= state_nx;
    end
  end

  assign z = (state == FULL);

  // Saturating match counter; clear has priority over a same-cycle match
  always_ff @(posedge CLKPORT or negedge reset_n) begin
    if (!reset_n) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (step && state_nx == FULL && !(&match_cnt)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end

  // Digit multiplexing straight from the divider and the live outputs
  always_comb begin
    state4                = '0;
    state4[STATE_W-1:0]   = state;
    cnt8                  = '0;
    cnt8[CNT_W-1:0]       = match_cnt;
    dig                   = clk_div[SCAN_BIT+1:SCAN_BIT];
    an                    = ~(4'b0001 << dig);
    case (dig)
      DIG_STATE:  dig_val = state4;
      DIG_Z:      dig_val = {3'b000, z};
      DIG_CNT_LO: dig_val = cnt8[3:0];
      default:    dig_val = cnt8[7:4];
    endcase
    seg = hex_to_seg(dig_val);
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seqdet_gen.sv
// tb/tb_seqdet_gen.sv - scoreboard bench for seqdet_gen
module tb_seqdet_gen;

  logic       CLKPORT  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       step_btn = 1'b0;
  logic       x        = 1'b0;
  logic       overlap  = 1'b0;
  logic       clr_cnt  = 1'b0;
  logic [3:0] pattern  = 4'b1011;

  logic       z, z4, dp, dp4;
  logic [2:0] state, state4;
  logic [7:0] match_cnt;
  logic [3:0] match_cnt4;
  logic [3:0] an, an4;
  logic [6:0] seg, seg4;

  localparam logic [6:0] E_SEG_0 = 7'b1000000;
  localparam logic [6:0] E_SEG_1 = 7'b1111001;
  localparam logic [6:0] E_SEG_2 = 7'b0100100;
  localparam logic [6:0] E_SEG_4 = 7'b0011001;
  localparam logic [6:0] E_SEG_A = 7'b0001000;

  always #5 CLKPORT = ~CLKPORT;

  seqdet_gen #(.PAT_LEN(4), .CNT_W(8), .SCAN_BIT(2)) dut (
    .CLKPORT(CLKPORT), .reset_n(reset_n), .step_btn(step_btn), .x(x),
    .pattern(pattern), .overlap(overlap), .clr_cnt(clr_cnt),
    .z(z), .state(state), .match_cnt(match_cnt), .an(an), .seg(seg), .dp(dp)
  );

  seqdet_gen #(.PAT_LEN(4), .CNT_W(4), .SCAN_BIT(2)) dut4 (
    .CLKPORT(CLKPORT), .reset_n(reset_n), .step_btn(step_btn), .x(x),
    .pattern(pattern), .overlap(overlap), .clr_cnt(clr_cnt),
    .z(z4), .state(state4), .match_cnt(match_cnt4), .an(an4), .seg(seg4), .dp(dp4)
  );

  typedef struct packed {
    logic [2:0] st;
    logic       zf;
    logic [7:0] c8;
    logic [3:0] c4;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_c8 = 0;
  int   exp_c4 = 0;
  int   pulse_cnt = 0;
  int   run = 0;
  int   max_run = 0;
  int   tick_miss = 0;

  always @(negedge CLKPORT) begin
    if (dut.step) begin
      pulse_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic do_step(input logic xv, input logic clr, input int exp_st);
    rec_t e, o;
    bit   seen;
    if (clr) begin
      exp_c8 = 0;
      exp_c4 = 0;
    end else if (exp_st == 4) begin
      if (exp_c8 < 255) exp_c8++;
      if (exp_c4 < 15)  exp_c4++;
    end
    e.st = 3'(exp_st);
    e.zf = (exp_st == 4);
    e.c8 = 8'(exp_c8);
    e.c4 = 4'(exp_c4);
    exp_q.push_back(e);
    x        = xv;
    step_btn = 1'b1;
    seen     = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge CLKPORT);
      seen = dut.step;
    end
    if (seen) begin
      clr_cnt = clr;
      @(negedge CLKPORT);
      o = {state, z, match_cnt, match_cnt4};
      clr_cnt = 1'b0;
    end else begin
      o = 'x;
    end
    obs_q.push_back(o);
    step_btn = 1'b0;
    repeat (12) @(negedge CLKPORT);
  endtask

  task automatic wait_tick();
    bit got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge CLKPORT);
      got = dut.tick;
    end
    if (!got) tick_miss++;
  endtask

  task automatic pulse_reset();
    @(negedge CLKPORT);
    reset_n = 1'b0;
    @(negedge CLKPORT);
    reset_n = 1'b1;
    exp_c8 = 0;
    exp_c4 = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge CLKPORT);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL reset_z: got %b expected 0", z); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", match_cnt); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL reset_an: got %b expected 1110", an); end
    checks++; if (seg !== E_SEG_0) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, E_SEG_0); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
    reset_n = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] xs   = 7'b1011011;
    int         st[7] = '{1, 2, 3, 4, 2, 3, 4};
    rec_t e, o;
    pattern = 4'b1011;
    overlap = 1'b1;
    for (int i = 0; i < 7; i++) do_step(xs[6-i], 1'b0, st[i]);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL overlap step %0d: got st=%0d z=%b c8=%0d c4=%0d expected st=%0d z=%b c8=%0d c4=%0d",
                 i, o.st, o.zf, o.c8, o.c4, e.st, e.zf, e.c8, e.c4);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit away = 1'b0;
    for (int n = 0; n < 8 && !away; n++) begin
      @(negedge CLKPORT);
      away = (an != 4'b1110);
    end
    checks++; if (!away) begin errors++; $display("FAIL mid_scan_reach: got an=%b expected not 1110", an); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_reset_state: got %0d expected 0", state); end
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL mid_reset_z: got %b expected 0", z); end
    checks++; if (match_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt: got %0d expected 0", match_cnt); end
    checks++; if (an !== 4'b1110) begin errors++; $display("FAIL mid_reset_an: got %b expected 1110", an); end
    checks++; if (seg !== E_SEG_0) begin errors++; $display("FAIL mid_reset_seg: got %b expected %b", seg, E_SEG_0); end
    @(negedge CLKPORT);
    reset_n = 1'b1;
    exp_c8 = 0;
    exp_c4 = 0;
  endtask

  task automatic test_non_overlap();
    logic [6:0] xs   = 7'b1011011;
    int         st[7] = '{1, 2, 3, 4, 0, 1, 1};
    rec_t e, o;
    pattern = 4'b1011;
    overlap = 1'b0;
    for (int i = 0; i < 7; i++) do_step(xs[6-i], 1'b0, st[i]);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL non_overlap step %0d: got st=%0d z=%b c8=%0d c4=%0d expected st=%0d z=%b c8=%0d c4=%0d",
                 i, o.st, o.zf, o.c8, o.c4, e.st, e.zf, e.c8, e.c4);
      end
    end
  endtask

  task automatic test_sat_clear();
    rec_t e, o;
    pulse_reset();
    pattern = 4'b1111;
    overlap = 1'b1;
    for (int i = 0; i < 20; i++) do_step(1'b1, 1'b0, (i < 3) ? i + 1 : 4);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturate step %0d: got st=%0d z=%b c8=%0d c4=%0d expected st=%0d z=%b c8=%0d c4=%0d",
                 i, o.st, o.zf, o.c8, o.c4, e.st, e.zf, e.c8, e.c4);
      end
    end
    checks++; if (match_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d expected 15", match_cnt4); end
    checks++; if (match_cnt !== 8'd17) begin errors++; $display("FAIL sat_cnt8: got %0d expected 17", match_cnt); end
    do_step(1'b1, 1'b1, 4);
    e = exp_q.pop_front();
    o = obs_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL clear_on_match: got st=%0d z=%b c8=%0d c4=%0d expected st=%0d z=%b c8=%0d c4=%0d",
               o.st, o.zf, o.c8, o.c4, e.st, e.zf, e.c8, e.c4);
    end
  endtask

  task automatic test_scan();
    rec_t       e, o;
    logic [3:0] prev_an = 4'b0000;
    logic [3:0] exp_an;
    logic [6:0] exp_seg[4] = '{E_SEG_4, E_SEG_1, E_SEG_A, E_SEG_2};
    bit         found = 1'b0;
    for (int i = 0; i < 42; i++) do_step(1'b1, 1'b0, 4);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL scan_fill step %0d: got st=%0d z=%b c8=%0d c4=%0d expected st=%0d z=%b c8=%0d c4=%0d",
                 i, o.st, o.zf, o.c8, o.c4, e.st, e.zf, e.c8, e.c4);
      end
    end
    for (int n = 0; n < 24 && !found; n++) begin
      @(negedge CLKPORT);
      found   = (an == 4'b1110) && (prev_an == 4'b0111);
      prev_an = an;
    end
    checks++; if (!found) begin errors++; $display("FAIL scan_wrap: got an=%b expected 0111 then 1110", an); end
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge CLKPORT);
      exp_an = ~(4'b0001 << (i / 4));
      checks++;
      if (an !== exp_an) begin errors++; $display("FAIL scan_an cycle %0d: got %b expected %b", i, an, exp_an); end
      if (i % 4 == 1) begin
        checks++;
        if (seg !== exp_seg[i/4]) begin
          errors++;
          $display("FAIL scan_seg digit %0d: got %b expected %b", i / 4, seg, exp_seg[i/4]);
        end
      end
    end
  endtask

  task automatic test_button();
    int base;
    base = pulse_cnt;
    for (int g = 0; g < 3; g++) begin
      wait_tick();
      @(posedge CLKPORT); #1 step_btn = 1'b1;
      @(posedge CLKPORT); #1 step_btn = 1'b0;
    end
    repeat (12) @(negedge CLKPORT);
    checks++; if (pulse_cnt - base !== 0) begin errors++; $display("FAIL glitch_pulses: got %0d expected 0", pulse_cnt - base); end
    step_btn = 1'b1;
    for (int t = 0; t < 40; t++) begin
      wait_tick();
      if (t == 10 || t == 20 || t == 30) begin
        @(posedge CLKPORT); #1 step_btn = 1'b0;
        @(posedge CLKPORT); #1 step_btn = 1'b1;
      end
    end
    step_btn = 1'b0;
    repeat (16) @(negedge CLKPORT);
    checks++; if (pulse_cnt - base !== 1) begin errors++; $display("FAIL hold_pulses: got %0d expected 1", pulse_cnt - base); end
    checks++; if (max_run !== 1) begin errors++; $display("FAIL pulse_width: got %0d expected 1", max_run); end
    checks++; if (tick_miss !== 0) begin errors++; $display("FAIL tick_seen: got %0d missed expected 0", tick_miss); end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_reset_mid();
    test_non_overlap();
    test_sat_clear();
    test_scan();
    test_button();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
